mem_bus_ctrl: RTL and testbench

Memory-bus controller between the CPU FSM and its memory system. It supersedes the combinational RAM read/write glue. It adds registered request capture, a configurable RAM read latency, `NIO` memory-mapped I/O ports, a one-cycle `mem_ready` completion handshake and bus-error reporting. It sits between the CPU's address-select/datapath outputs and the on-chip RAM plus I/O devices.

---
 rtl/mem_bus_pkg.sv | 27 ++
 rtl/RegWithLoad.sv | 17 +
 rtl/io_read_mux.sv | 19 +
 rtl/mem_bus_ctrl.sv | 147 ++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared encodings, state enum and helpers for the memory-bus controller
package mem_bus_pkg;

    localparam logic [1:0] MNONE    = 2'b00;
    localparam logic [1:0] MWRITE   = 2'b01;
    localparam logic [1:0] MREAD    = 2'b10;
    localparam logic [1:0] MILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        IO_RD   = 3'd2,
        WR      = 3'd3,
        ERR     = 3'd4,
        RESP    = 3'd5
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/RegWithLoad.sv
// rtl/RegWithLoad.sv - W-bit register with load enable and synchronous active-low clear
module RegWithLoad #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!reset_n) q <= '0;
        else if (load) q <= d;
    end

endmodule

// File: rtl/io_read_mux.sv
// rtl/io_read_mux.sv - selects one DW-wide slice of the packed I/O read bus by port index
module io_read_mux #(
    parameter int NIO = 2,
    parameter int DW  = 16,
    parameter int IW  = 1
) (
    input  logic [NIO*DW-1:0] data,
    input  logic [IW-1:0]     idx,
    output logic [DW-1:0]     sel
);

    always_comb begin
        sel = '0;
        for (int i = 0; i < NIO; i++) begin
            if (idx == IW'(i)) sel = data[i*DW +: DW];
        end
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - registered CPU memory-bus controller: RAM with read latency, MMIO ports, bus errors
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int AW       = 9,
    parameter int DW       = 16,
    parameter int RAM_AW   = 8,
    parameter int READ_LAT = 1,
    parameter int NIO      = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        mem_cmd,
    input  logic [AW-1:0]     mem_addr,
    input  logic [DW-1:0]     write_data,
    output logic              mem_ready,
    output logic [DW-1:0]     read_data,
    output logic              bus_err,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_write,
    output logic [DW-1:0]     ram_wdata,
    input  logic [DW-1:0]     ram_rdata,
    output logic [NIO-1:0]    io_rd_strobe,
    output logic [NIO-1:0]    io_wr_strobe,
    output logic [DW-1:0]     io_wdata,
    input  logic [NIO*DW-1:0] io_rdata
);

    localparam int IW = (clog2(NIO) < 1) ? 1 : clog2(NIO);
    localparam int CW = (clog2(READ_LAT) < 1) ? 1 : clog2(READ_LAT);
    localparam logic [IW:0]   NIO_V    = (IW+1)'(NIO);
    localparam logic [CW-1:0] LAT_INIT = CW'(READ_LAT - 1);

    // Address-range faults; used both to classify a new request and to guard strobes.
    function automatic logic addr_err(input logic [AW-1:0] a);
        logic [AW-2:0] low;
        low = a[AW-2:0];
        if (a[AW-1]) return ((low >> IW) != '0) || ({1'b0, low[IW-1:0]} >= NIO_V);
        return (low >> RAM_AW) != '0;
    endfunction

    state_t          state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic            accept;
    logic [1:0]      cap_cmd;
    logic [AW-1:0]   cap_addr;
    logic [DW-1:0]   cap_wdata;
    logic            in_err, cap_bad, cap_io;
    logic [IW-1:0]   cap_idx;
    logic [NIO-1:0]  idx_onehot;
    logic [DW-1:0]   io_sel;
    logic            rd_load;
    logic [DW-1:0]   rd_src;

    assign accept = (state == IDLE) && (mem_cmd != MNONE);
    assign in_err = (mem_cmd == MILLEGAL) || addr_err(mem_addr);

    RegWithLoad #(.W(2))  u_cap_cmd   (.clk(clk), .reset_n(reset_n), .load(accept), .d(mem_cmd),    .q(cap_cmd));
    RegWithLoad #(.W(AW)) u_cap_addr  (.clk(clk), .reset_n(reset_n), .load(accept), .d(mem_addr),   .q(cap_addr));
    RegWithLoad #(.W(DW)) u_cap_wdata (.clk(clk), .reset_n(reset_n), .load(accept), .d(write_data), .q(cap_wdata));
    RegWithLoad #(.W(DW)) u_read_data (.clk(clk), .reset_n(reset_n), .load(rd_load), .d(rd_src),    .q(read_data));

    assign cap_io     = cap_addr[AW-1];
    assign cap_idx    = cap_addr[IW-1:0];
    assign cap_bad    = (cap_cmd == MILLEGAL) || addr_err(cap_addr);
    assign idx_onehot = NIO'(1) << cap_idx;

    assign ram_addr  = cap_addr[RAM_AW-1:0];
    assign ram_wdata = cap_wdata;
    assign io_wdata  = cap_wdata;

    io_read_mux #(.NIO(NIO), .DW(DW), .IW(IW)) u_io_mux (
        .data (io_rdata),
        .idx  (cap_idx),
        .sel  (io_sel)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (mem_cmd != MNONE) begin
                    if (in_err) state_next = ERR;
                    else if (mem_cmd == MWRITE) state_next = WR;
                    else if (mem_cmd == MREAD) begin
                        if (mem_addr[AW-1]) state_next = IO_RD;
                        else begin
                            state_next = RD_WAIT;
                            cnt_next   = LAT_INIT;
                        end
                    end
                end
            end
            RD_WAIT: begin
                if (cnt == '0) state_next = RESP;
                else cnt_next = cnt - CW'(1);
            end
            IO_RD:   state_next = RESP;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_ready    = 1'b0;
        bus_err      = 1'b0;
        ram_write    = 1'b0;
        io_rd_strobe = '0;
        io_wr_strobe = '0;
        rd_load      = 1'b0;
        rd_src       = ram_rdata;
        case (state)
            WR: begin
                mem_ready = 1'b1;
                if (!cap_bad && cap_cmd == MWRITE) begin
                    if (cap_io) io_wr_strobe = idx_onehot;
                    else ram_write = 1'b1;
                end
            end
            IO_RD: begin
                if (!cap_bad) begin
                    io_rd_strobe = idx_onehot;
                    rd_load      = 1'b1;
                    rd_src       = io_sel;
                end
            end
            RD_WAIT: rd_load = (cnt == '0);
            ERR: begin
                mem_ready = 1'b1;
                bus_err   = 1'b1;
            end
            RESP:    mem_ready = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb/tb_mem_bus_ctrl.sv - directed self-checking bench for mem_bus_ctrl at READ_LAT 1 and 3
module tb_mem_bus_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  cmd1, cmd3;
    logic [8:0]  addr1, addr3;
    logic [15:0] wd1, wd3;
    logic        ready1, ready3, berr1, berr3;
    logic [15:0] rd1, rd3;
    logic [7:0]  ra1, ra3;
    logic        rw1, rw3;
    logic [15:0] rwd1, rwd3, rrd1, rrd3;
    logic [1:0]  irs1, irs3, iws1, iws3;
    logic [15:0] iwd1, iwd3;
    logic [31:0] ird1, ird3;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_bus_ctrl #(.AW(9), .DW(16), .RAM_AW(8), .READ_LAT(1), .NIO(2)) dut1 (
        .clk(clk), .reset_n(reset_n), .mem_cmd(cmd1), .mem_addr(addr1), .write_data(wd1),
        .mem_ready(ready1), .read_data(rd1), .bus_err(berr1), .ram_addr(ra1), .ram_write(rw1),
        .ram_wdata(rwd1), .ram_rdata(rrd1), .io_rd_strobe(irs1), .io_wr_strobe(iws1),
        .io_wdata(iwd1), .io_rdata(ird1)
    );

    mem_bus_ctrl #(.AW(9), .DW(16), .RAM_AW(8), .READ_LAT(3), .NIO(2)) dut3 (
        .clk(clk), .reset_n(reset_n), .mem_cmd(cmd3), .mem_addr(addr3), .write_data(wd3),
        .mem_ready(ready3), .read_data(rd3), .bus_err(berr3), .ram_addr(ra3), .ram_write(rw3),
        .ram_wdata(rwd3), .ram_rdata(rrd3), .io_rd_strobe(irs3), .io_wr_strobe(iws3),
        .io_wdata(iwd3), .io_rdata(ird3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cmd1 = 2'b00; addr1 = '0; wd1 = '0; rrd1 = '0; ird1 = '0;
        cmd3 = 2'b00; addr3 = '0; wd3 = '0; rrd3 = '0; ird3 = '0;
        repeat (3) step();
        checks++; if ({ready1, berr1, rw1, irs1, iws1} !== 7'b0) begin errors++; $display("FAIL reset_ctl1 got %b exp 0", {ready1, berr1, rw1, irs1, iws1}); end
        checks++; if ({ready3, berr3, rw3, irs3, iws3} !== 7'b0) begin errors++; $display("FAIL reset_ctl3 got %b exp 0", {ready3, berr3, rw3, irs3, iws3}); end
        checks++; if ({rd1, ra1, rwd1} !== 40'h0) begin errors++; $display("FAIL reset_data1 got %h exp 0", {rd1, ra1, rwd1}); end
        checks++; if ({rd3, ra3, iwd3} !== 40'h0) begin errors++; $display("FAIL reset_data3 got %h exp 0", {rd3, ra3, iwd3}); end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_ram_write();
        cmd1 = 2'b01; addr1 = 9'h012; wd1 = 16'hBEEF;
        step();
        cmd1 = 2'b00;
        checks++; if ({rw1, ready1, berr1} !== 3'b110) begin errors++; $display("FAIL ramwr_ctl got %b exp 110", {rw1, ready1, berr1}); end
        checks++; if (ra1 !== 8'h12) begin errors++; $display("FAIL ramwr_addr got %h exp 12", ra1); end
        checks++; if (rwd1 !== 16'hBEEF) begin errors++; $display("FAIL ramwr_wdata got %h exp beef", rwd1); end
        step();
        checks++; if ({rw1, ready1} !== 2'b00) begin errors++; $display("FAIL ramwr_idle got %b exp 00", {rw1, ready1}); end
    endtask

    task automatic test_ram_read_lat1();
        cmd1 = 2'b10; addr1 = 9'h012; rrd1 = 16'hBEEF;
        step();
        cmd1 = 2'b00;
        checks++; if (ready1 !== 1'b0) begin errors++; $display("FAIL rd1_early_ready got %b exp 0", ready1); end
        step();
        checks++; if ({ready1, berr1} !== 2'b10) begin errors++; $display("FAIL rd1_ready got %b exp 10", {ready1, berr1}); end
        checks++; if (rd1 !== 16'hBEEF) begin errors++; $display("FAIL rd1_data got %h exp beef", rd1); end
        step();
    endtask

    task automatic test_ram_read_lat3();
        cmd3 = 2'b10; addr3 = 9'h0FF; rrd3 = 16'h1234;
        step();
        cmd3 = 2'b00;
        for (int i = 1; i <= 3; i++) begin
            checks++; if (ready3 !== 1'b0) begin errors++; $display("FAIL rd3_wait_ready cyc %0d got %b exp 0", i, ready3); end
            checks++; if (ra3 !== 8'hFF) begin errors++; $display("FAIL rd3_wait_addr cyc %0d got %h exp ff", i, ra3); end
            step();
        end
        checks++; if (ready3 !== 1'b1) begin errors++; $display("FAIL rd3_ready got %b exp 1", ready3); end
        checks++; if (rd3 !== 16'h1234) begin errors++; $display("FAIL rd3_data got %h exp 1234", rd3); end
        step();
        checks++; if (ready3 !== 1'b0) begin errors++; $display("FAIL rd3_after got %b exp 0", ready3); end
    endtask

    task automatic test_io();
        ird1 = {16'h2222, 16'h1111};
        cmd1 = 2'b10; addr1 = 9'h101;
        step();
        cmd1 = 2'b00;
        checks++; if ({irs1, ready1} !== 3'b100) begin errors++; $display("FAIL iord_strobe got %b exp 100", {irs1, ready1}); end
        step();
        checks++; if ({irs1, ready1, berr1} !== 4'b0010) begin errors++; $display("FAIL iord_ready got %b exp 0010", {irs1, ready1, berr1}); end
        checks++; if (rd1 !== 16'h2222) begin errors++; $display("FAIL iord_data got %h exp 2222", rd1); end
        step();
        cmd1 = 2'b01; addr1 = 9'h100; wd1 = 16'h00A5;
        step();
        cmd1 = 2'b00;
        checks++; if ({iws1, rw1, ready1} !== 4'b0101) begin errors++; $display("FAIL iowr_ctl got %b exp 0101", {iws1, rw1, ready1}); end
        checks++; if (iwd1 !== 16'h00A5) begin errors++; $display("FAIL iowr_data got %h exp 00a5", iwd1); end
        step();
        checks++; if (iws1 !== 2'b00) begin errors++; $display("FAIL iowr_idle got %b exp 00", iws1); end
    endtask

    task automatic test_errors();
        logic [1:0] ecmd [3];
        logic [8:0] eaddr [3];
        ecmd  = '{2'b11, 2'b10, 2'b01};
        eaddr = '{9'h012, 9'h103, 9'h1F0};
        for (int i = 0; i < 3; i++) begin
            cmd1 = ecmd[i]; addr1 = eaddr[i]; wd1 = 16'hDEAD;
            step();
            cmd1 = 2'b00;
            checks++; if ({ready1, berr1} !== 2'b11) begin errors++; $display("FAIL err%0d_flags got %b exp 11", i, {ready1, berr1}); end
            checks++; if ({rw1, irs1, iws1} !== 5'b0) begin errors++; $display("FAIL err%0d_strobes got %b exp 0", i, {rw1, irs1, iws1}); end
            step();
            checks++; if (rd1 !== 16'h2222) begin errors++; $display("FAIL err%0d_rdata got %h exp 2222", i, rd1); end
            checks++; if ({ready1, berr1} !== 2'b00) begin errors++; $display("FAIL err%0d_idle got %b exp 00", i, {ready1, berr1}); end
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        cmd3 = 2'b10; addr3 = 9'h0FF; rrd3 = 16'h5678;
        step();
        cmd3 = 2'b00;
        step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        checks++; if ({ready3, berr3, rw3, irs3, iws3} !== 7'b0) begin errors++; $display("FAIL rstmid_ctl got %b exp 0", {ready3, berr3, rw3, irs3, iws3}); end
        checks++; if ({rd3, ra3} !== 24'h0) begin errors++; $display("FAIL rstmid_data got %h exp 0", {rd3, ra3}); end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (ready3) seen++;
            step();
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_noready got %0d exp 0", seen); end
        cmd3 = 2'b01; addr3 = 9'h034; wd3 = 16'h0001;
        step();
        cmd3 = 2'b00;
        checks++; if ({rw3, ready3, ra3, rwd3} !== {2'b11, 8'h34, 16'h0001}) begin errors++; $display("FAIL rstmid_next got %h exp %h", {rw3, ready3, ra3, rwd3}, {2'b11, 8'h34, 16'h0001}); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_rw;
        exp_rw = 4'b0101;
        cmd1 = 2'b01; addr1 = 9'h020; wd1 = 16'h0042;
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 2) cmd1 = 2'b00;
            checks++; if ({rw1, ready1} !== {2{exp_rw[i]}}) begin errors++; $display("FAIL held_cyc%0d got %b exp %b", i + 1, {rw1, ready1}, {2{exp_rw[i]}}); end
        end
    endtask

    initial begin
        test_reset();
        test_ram_write();
        test_ram_read_lat1();
        test_ram_read_lat3();
        test_io();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
